// File: rtl/sisc_exec_ctrl_if.sv
// Bus between the SISC execution/control core and the surrounding datapath
// (IR, register file, status register, PC, data memory, write-back muxes).
interface sisc_exec_ctrl_if;
   logic [31:0] instruction;
   logic [3:0]  stat;
   logic [31:0] rsa;
   logic [31:0] rsb;
   logic [15:0] pc_out;

   logic [31:0] alu_result;
   logic [3:0]  cc;
   logic        stat_en;
   logic [15:0] br_out;
   logic        rf_we;
   logic [1:0]  wb_sel;
   logic        rb_sel;
   logic        swap_sel;
   logic        swap_ctrl;
   logic        pc_sel;
   logic        pc_write;
   logic        pc_rst;
   logic        ir_load;
   logic        mux_16_sel;
   logic        dm_we;

   // The core drives the control side of the bus.
   modport master (
      input  instruction, stat, rsa, rsb, pc_out,
      output alu_result, cc, stat_en, br_out, rf_we, wb_sel, rb_sel,
             swap_sel, swap_ctrl, pc_sel, pc_write, pc_rst, ir_load,
             mux_16_sel, dm_we
   );

   modport slave (
      output instruction, stat, rsa, rsb, pc_out,
      input  alu_result, cc, stat_en, br_out, rf_we, wb_sel, rb_sel,
             swap_sel, swap_ctrl, pc_sel, pc_write, pc_rst, ir_load,
             mux_16_sel, dm_we
   );
endinterface

// File: rtl/sisc_exec_ctrl.sv
// SISC execution/control core: ALU with condition codes, branch-target adder
// and the multi-cycle fetch/decode/execute/mem/writeback sequencer.
module sisc_exec_ctrl (
   input  logic              clk,
   input  logic              rst_f,
   sisc_exec_ctrl_if.master  bus
);

   localparam logic [3:0] OP_ALU_REG = 4'd1;
   localparam logic [3:0] OP_ALU_IMM = 4'd2;
   localparam logic [3:0] OP_SWAP    = 4'd3;
   localparam logic [3:0] OP_LOD     = 4'd8;
   localparam logic [3:0] OP_STR     = 4'd9;
   localparam logic [3:0] OP_HLT     = 4'd15;

   typedef enum logic [3:0] {
      START0, START1, FETCH, DECODE, EXECUTE, MEM, WB, WB2, HALT
   } state_t;

   state_t      state, next_state;
   logic [31:0] swap_hold;

   logic [3:0]  op, mm;
   logic [15:0] imm;
   logic        unused_fields;

   assign op  = bus.instruction[31:28];
   assign mm  = bus.instruction[27:24];
   assign imm = bus.instruction[15:0];
   assign unused_fields = ^bus.instruction[23:16];

   logic [31:0] op_a, op_b, alu_val;
   logic [3:0]  func;
   logic        carry, ovf;

   // Loads/stores reuse the adder for address generation with an unsigned offset.
   always_comb begin
      op_a    = bus.rsa;
      op_b    = bus.rsb;
      func    = mm;
      alu_val = op_a;
      carry   = 1'b0;
      ovf     = 1'b0;
      if (op == OP_ALU_IMM) begin
         op_b = {{16{imm[15]}}, imm};
      end else if (op == OP_LOD || op == OP_STR) begin
         op_b = {16'h0000, imm};
         func = 4'd1;
      end
      case (func)
         4'd1: begin
            {carry, alu_val} = {1'b0, op_a} + {1'b0, op_b};
            ovf = (op_a[31] == op_b[31]) && (alu_val[31] != op_a[31]);
         end
         4'd2: begin
            alu_val = op_a - op_b;
            carry   = (op_a < op_b);
            ovf     = (op_a[31] != op_b[31]) && (alu_val[31] != op_a[31]);
         end
         4'd3: alu_val = op_a & op_b;
         4'd4: alu_val = op_a | op_b;
         4'd5: alu_val = op_a ^ op_b;
         4'd6: alu_val = ~op_a;
         4'd7: begin
            alu_val = {op_a[30:0], 1'b0};
            carry   = op_a[31];
         end
         4'd8: begin
            alu_val = {1'b0, op_a[31:1]};
            carry   = op_a[0];
         end
         default: alu_val = op_a;
      endcase
   end

   assign bus.cc         = {carry, ovf, alu_val[31], (alu_val == 32'h0)};
   assign bus.alu_result = (state == WB2) ? swap_hold : alu_val;

   logic branch_op, branch_taken;
   assign branch_op    = (op[3:2] == 2'b01);
   assign branch_taken = op[1] ? ((bus.stat & mm) == 4'h0) : ((bus.stat & mm) != 4'h0);
   assign bus.br_out   = op[0] ? (bus.pc_out + imm) : imm;

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state     <= START0;
         swap_hold <= 32'h0;
      end else begin
         state <= next_state;
         if (state == EXECUTE && op == OP_SWAP)
            swap_hold <= bus.rsb;
      end
   end

   // Next-state and Moore control decode; everything idles low unless a state claims it.
   always_comb begin
      next_state     = state;
      bus.stat_en    = 1'b0;
      bus.rf_we      = 1'b0;
      bus.wb_sel     = 2'b00;
      bus.rb_sel     = 1'b0;
      bus.swap_sel   = 1'b0;
      bus.swap_ctrl  = 1'b0;
      bus.pc_sel     = 1'b0;
      bus.pc_write   = 1'b0;
      bus.pc_rst     = 1'b0;
      bus.ir_load    = 1'b0;
      bus.mux_16_sel = 1'b0;
      bus.dm_we      = 1'b0;

      if (state inside {DECODE, EXECUTE, MEM, WB, WB2} && (op == OP_SWAP || op == OP_STR))
         bus.rb_sel = 1'b1;

      case (state)
         START0: begin
            bus.pc_rst = 1'b1;
            next_state = START1;
         end
         START1: begin
            bus.pc_rst = 1'b1;
            next_state = FETCH;
         end
         FETCH: begin
            bus.ir_load  = 1'b1;
            bus.pc_write = 1'b1;
            next_state   = DECODE;
         end
         DECODE: begin
            if (branch_op && branch_taken) begin
               bus.pc_sel   = 1'b1;
               bus.pc_write = 1'b1;
            end
            next_state = (op == OP_HLT) ? HALT : EXECUTE;
         end
         EXECUTE: begin
            bus.stat_en = (op == OP_ALU_REG || op == OP_ALU_IMM);
            next_state  = MEM;
         end
         MEM: begin
            if (op == OP_LOD || op == OP_STR)
               bus.mux_16_sel = mm[0];
            bus.dm_we  = (op == OP_STR);
            next_state = WB;
         end
         WB: begin
            if (op == OP_ALU_REG || op == OP_ALU_IMM) begin
               bus.rf_we = 1'b1;
            end else if (op == OP_LOD) begin
               bus.rf_we  = 1'b1;
               bus.wb_sel = 2'b01;
            end else if (op == OP_SWAP) begin
               bus.rf_we  = 1'b1;
               bus.wb_sel = 2'b10;
            end
            next_state = (op == OP_SWAP) ? WB2 : FETCH;
         end
         WB2: begin
            bus.rf_we     = 1'b1;
            bus.swap_sel  = 1'b1;
            bus.swap_ctrl = 1'b1;
            next_state    = FETCH;
         end
         HALT:    next_state = HALT;
         default: next_state = START0;
      endcase
   end

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// Directed testbench for sisc_exec_ctrl: walks each instruction class through
// its states and compares control outputs and ALU/branch results to hand values.
module tb_sisc_exec_ctrl;

   logic clk;
   logic rst_f;
   int   errors = 0;
   int   checks = 0;

   sisc_exec_ctrl_if bus ();

   sisc_exec_ctrl dut (
      .clk   (clk),
      .rst_f (rst_f),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed control view: {stat_en,rf_we,wb_sel[1:0],rb_sel,swap_sel,swap_ctrl,pc_sel,pc_write,pc_rst,ir_load,mux_16_sel,dm_we}
   logic [12:0] ctrl;
   assign ctrl = {bus.stat_en, bus.rf_we, bus.wb_sel, bus.rb_sel, bus.swap_sel,
                  bus.swap_ctrl, bus.pc_sel, bus.pc_write, bus.pc_rst,
                  bus.ir_load, bus.mux_16_sel, bus.dm_we};

   localparam logic [12:0] C_IDLE   = 13'b0_0_00_0_0_0_0_0_0_0_0_0;
   localparam logic [12:0] C_PCRST  = 13'b0_0_00_0_0_0_0_0_1_0_0_0;
   localparam logic [12:0] C_FETCH  = 13'b0_0_00_0_0_0_0_1_0_1_0_0;
   localparam logic [12:0] C_STATEN = 13'b1_0_00_0_0_0_0_0_0_0_0_0;
   localparam logic [12:0] C_WB_ALU = 13'b0_1_00_0_0_0_0_0_0_0_0_0;
   localparam logic [12:0] C_BRANCH = 13'b0_0_00_0_0_0_1_1_0_0_0_0;
   localparam logic [12:0] C_RBSEL  = 13'b0_0_00_1_0_0_0_0_0_0_0_0;
   localparam logic [12:0] C_WB_SWP = 13'b0_1_10_1_0_0_0_0_0_0_0_0;
   localparam logic [12:0] C_WB2    = 13'b0_1_00_1_1_1_0_0_0_0_0_0;
   localparam logic [12:0] C_STR_M  = 13'b0_0_00_1_0_0_0_0_0_0_1_1;
   localparam logic [12:0] C_WB_LOD = 13'b0_1_01_0_0_0_0_0_0_0_0_0;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_f = 1'b0;
      step(2);
      rst_f = 1'b1;
      step(2);
   endtask

   task automatic test_reset();
      bus.instruction = 32'h0;
      bus.stat        = 4'h0;
      bus.rsa         = 32'h0;
      bus.rsb         = 32'h0;
      bus.pc_out      = 16'h0;
      rst_f           = 1'b0;
      #12;
      checks++;
      if (ctrl !== C_PCRST) begin
         errors++; $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl, C_PCRST);
      end
      rst_f = 1'b1;
      #1;
      checks++;
      if (ctrl !== C_PCRST) begin
         errors++; $display("[TB] FAIL start0_ctrl: got %b expected %b", ctrl, C_PCRST);
      end
      step(1);
      checks++;
      if (ctrl !== C_PCRST) begin
         errors++; $display("[TB] FAIL start1_ctrl: got %b expected %b", ctrl, C_PCRST);
      end
      step(1);
      checks++;
      if (ctrl !== C_FETCH) begin
         errors++; $display("[TB] FAIL fetch_ctrl: got %b expected %b", ctrl, C_FETCH);
      end
   endtask

   task automatic test_alu_add();
      bus.instruction = {4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 12'h000};
      bus.rsa = 32'h7FFF_FFFF;
      bus.rsb = 32'h0000_0001;
      step(1);
      checks++;
      if (ctrl !== C_IDLE) begin
         errors++; $display("[TB] FAIL add_decode_ctrl: got %b expected %b", ctrl, C_IDLE);
      end
      step(1);
      checks++;
      if (bus.alu_result !== 32'h8000_0000) begin
         errors++; $display("[TB] FAIL add_result: got %h expected %h", bus.alu_result, 32'h8000_0000);
      end
      checks++;
      if (bus.cc !== 4'b0110) begin
         errors++; $display("[TB] FAIL add_cc: got %b expected %b", bus.cc, 4'b0110);
      end
      checks++;
      if (ctrl !== C_STATEN) begin
         errors++; $display("[TB] FAIL add_exec_ctrl: got %b expected %b", ctrl, C_STATEN);
      end
      step(1);
      checks++;
      if (ctrl !== C_IDLE) begin
         errors++; $display("[TB] FAIL add_mem_ctrl: got %b expected %b", ctrl, C_IDLE);
      end
      step(1);
      checks++;
      if (ctrl !== C_WB_ALU) begin
         errors++; $display("[TB] FAIL add_wb_ctrl: got %b expected %b", ctrl, C_WB_ALU);
      end
      step(1);
      checks++;
      if (ctrl !== C_FETCH) begin
         errors++; $display("[TB] FAIL add_refetch_ctrl: got %b expected %b", ctrl, C_FETCH);
      end
   endtask

   task automatic test_alu_sub();
      bus.instruction = {4'h1, 4'h2, 24'h000000};
      bus.rsa = 32'd5;
      bus.rsb = 32'd5;
      step(2);
      checks++;
      if (bus.alu_result !== 32'h0 || bus.cc !== 4'b0001) begin
         errors++; $display("[TB] FAIL sub_equal: got %h/%b expected %h/%b", bus.alu_result, bus.cc, 32'h0, 4'b0001);
      end
      step(3);
      bus.rsa = 32'd1;
      bus.rsb = 32'd2;
      step(2);
      checks++;
      if (bus.alu_result !== 32'hFFFF_FFFF || bus.cc !== 4'b1010) begin
         errors++; $display("[TB] FAIL sub_borrow: got %h/%b expected %h/%b", bus.alu_result, bus.cc, 32'hFFFF_FFFF, 4'b1010);
      end
      step(3);
   endtask

   task automatic test_alu_misc();
      // ALU-imm ADD with 0xFFFF sign-extends to -1: 5 + (-1) = 4 with carry out.
      bus.instruction = {4'h2, 4'h1, 8'h00, 16'hFFFF};
      bus.rsa = 32'd5;
      bus.rsb = 32'h1234_5678;
      step(2);
      checks++;
      if (bus.alu_result !== 32'd4 || bus.cc !== 4'b1000) begin
         errors++; $display("[TB] FAIL imm_sext_add: got %h/%b expected %h/%b", bus.alu_result, bus.cc, 32'd4, 4'b1000);
      end
      checks++;
      if (ctrl !== C_STATEN) begin
         errors++; $display("[TB] FAIL imm_exec_ctrl: got %b expected %b", ctrl, C_STATEN);
      end
      step(3);
      bus.instruction = {4'h1, 4'h7, 24'h000000};
      bus.rsa = 32'h8000_0001;
      step(2);
      checks++;
      if (bus.alu_result !== 32'h0000_0002 || bus.cc !== 4'b1000) begin
         errors++; $display("[TB] FAIL shl: got %h/%b expected %h/%b", bus.alu_result, bus.cc, 32'h2, 4'b1000);
      end
      step(3);
      bus.instruction = {4'h1, 4'h8, 24'h000000};
      bus.rsa = 32'h0000_0001;
      step(2);
      checks++;
      if (bus.alu_result !== 32'h0 || bus.cc !== 4'b1001) begin
         errors++; $display("[TB] FAIL shr: got %h/%b expected %h/%b", bus.alu_result, bus.cc, 32'h0, 4'b1001);
      end
      step(3);
      bus.instruction = {4'h1, 4'h5, 24'h000000};
      bus.rsa = 32'hF0F0_1234;
      bus.rsb = 32'h0FF0_1234;
      step(2);
      checks++;
      if (bus.alu_result !== 32'hFF00_0000 || bus.cc !== 4'b0010) begin
         errors++; $display("[TB] FAIL xor: got %h/%b expected %h/%b", bus.alu_result, bus.cc, 32'hFF00_0000, 4'b0010);
      end
      step(3);
   endtask

   task automatic test_branch();
      bus.instruction = {4'h5, 4'h1, 8'h00, 16'hFFFE};
      bus.stat   = 4'b0001;
      bus.pc_out = 16'h0011;
      step(1);
      checks++;
      if (bus.br_out !== 16'h000F) begin
         errors++; $display("[TB] FAIL brr_target: got %h expected %h", bus.br_out, 16'h000F);
      end
      checks++;
      if (ctrl !== C_BRANCH) begin
         errors++; $display("[TB] FAIL brr_taken_ctrl: got %b expected %b", ctrl, C_BRANCH);
      end
      step(3);
      checks++;
      if (ctrl !== C_IDLE) begin
         errors++; $display("[TB] FAIL brr_wb_ctrl: got %b expected %b", ctrl, C_IDLE);
      end
      step(1);
      bus.stat = 4'b0000;
      step(1);
      checks++;
      if (ctrl !== C_IDLE) begin
         errors++; $display("[TB] FAIL brr_not_taken_ctrl: got %b expected %b", ctrl, C_IDLE);
      end
      step(4);
      bus.instruction = {4'h6, 4'h2, 8'h00, 16'h1234};
      bus.stat = 4'b0001;
      step(1);
      checks++;
      if (bus.br_out !== 16'h1234 || ctrl !== C_BRANCH) begin
         errors++; $display("[TB] FAIL bne_taken: got %h/%b expected %h/%b", bus.br_out, ctrl, 16'h1234, C_BRANCH);
      end
      step(4);
   endtask

   task automatic test_swap();
      bus.instruction = {4'h3, 4'h0, 4'h2, 4'h5, 16'h0000};
      bus.rsa = 32'h0000_000A;
      bus.rsb = 32'h0000_000B;
      step(1);
      checks++;
      if (ctrl !== C_RBSEL) begin
         errors++; $display("[TB] FAIL swap_decode_ctrl: got %b expected %b", ctrl, C_RBSEL);
      end
      step(1);
      checks++;
      if (ctrl !== C_RBSEL) begin
         errors++; $display("[TB] FAIL swap_exec_ctrl: got %b expected %b", ctrl, C_RBSEL);
      end
      step(1);
      bus.rsb = 32'h0000_0077;
      step(1);
      checks++;
      if (ctrl !== C_WB_SWP) begin
         errors++; $display("[TB] FAIL swap_wb_ctrl: got %b expected %b", ctrl, C_WB_SWP);
      end
      step(1);
      checks++;
      if (ctrl !== C_WB2) begin
         errors++; $display("[TB] FAIL swap_wb2_ctrl: got %b expected %b", ctrl, C_WB2);
      end
      checks++;
      if (bus.alu_result !== 32'h0000_000B) begin
         errors++; $display("[TB] FAIL swap_hold_value: got %h expected %h", bus.alu_result, 32'h0000_000B);
      end
      step(1);
      checks++;
      if (ctrl !== C_FETCH) begin
         errors++; $display("[TB] FAIL swap_refetch_ctrl: got %b expected %b", ctrl, C_FETCH);
      end
   endtask

   task automatic test_load_store();
      bus.instruction = {4'h9, 4'h1, 4'h2, 4'h3, 16'h0004};
      bus.rsa = 32'h0000_0010;
      step(3);
      checks++;
      if (bus.alu_result[15:0] !== 16'h0014) begin
         errors++; $display("[TB] FAIL str_addr: got %h expected %h", bus.alu_result[15:0], 16'h0014);
      end
      checks++;
      if (ctrl !== C_STR_M) begin
         errors++; $display("[TB] FAIL str_mem_ctrl: got %b expected %b", ctrl, C_STR_M);
      end
      step(1);
      checks++;
      if (ctrl !== C_RBSEL) begin
         errors++; $display("[TB] FAIL str_wb_ctrl: got %b expected %b", ctrl, C_RBSEL);
      end
      step(1);
      bus.instruction = {4'h8, 4'h0, 4'h2, 4'h3, 16'h0020};
      step(3);
      checks++;
      if (ctrl !== C_IDLE) begin
         errors++; $display("[TB] FAIL lod_mem_ctrl: got %b expected %b", ctrl, C_IDLE);
      end
      step(1);
      checks++;
      if (ctrl !== C_WB_LOD) begin
         errors++; $display("[TB] FAIL lod_wb_ctrl: got %b expected %b", ctrl, C_WB_LOD);
      end
      step(1);
   endtask

   task automatic test_reset_abort();
      bus.instruction = {4'h1, 4'h1, 24'h000000};
      step(2);
      checks++;
      if (ctrl !== C_STATEN) begin
         errors++; $display("[TB] FAIL abort_exec_ctrl: got %b expected %b", ctrl, C_STATEN);
      end
      #2;
      rst_f = 1'b0;
      #1;
      checks++;
      if (ctrl !== C_PCRST) begin
         errors++; $display("[TB] FAIL abort_async_ctrl: got %b expected %b", ctrl, C_PCRST);
      end
      step(2);
      rst_f = 1'b1;
      step(2);
      checks++;
      if (ctrl !== C_FETCH) begin
         errors++; $display("[TB] FAIL abort_restart_ctrl: got %b expected %b", ctrl, C_FETCH);
      end
   endtask

   task automatic test_halt();
      bus.instruction = {4'hF, 28'h0000000};
      step(1);
      checks++;
      if (ctrl !== C_IDLE) begin
         errors++; $display("[TB] FAIL hlt_decode_ctrl: got %b expected %b", ctrl, C_IDLE);
      end
      for (int i = 0; i < 4; i++) begin
         step(1);
         checks++;
         if (ctrl !== C_IDLE) begin
            errors++; $display("[TB] FAIL halt_hold_%0d: got %b expected %b", i, ctrl, C_IDLE);
         end
      end
      rst_f = 1'b0;
      #1;
      checks++;
      if (ctrl !== C_PCRST) begin
         errors++; $display("[TB] FAIL halt_reset_ctrl: got %b expected %b", ctrl, C_PCRST);
      end
      step(1);
      rst_f = 1'b1;
   endtask

   initial begin
      test_reset();
      test_alu_add();
      test_alu_sub();
      test_alu_misc();
      test_branch();
      test_swap();
      test_load_store();
      test_reset_abort();
      test_halt();
      do_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/sisc_exec_ctrl.md
Name: sisc_exec_ctrl

Overview:
- Execution/control core of the SISC multi-cycle processor, combining the ALU, the branch-target calculator and the control FSM.
- Sits between the instruction register, register file, status register, PC, data memory and write-back muxes.
- Decodes the IR, sequences fetch/decode/execute/mem/writeback, computes ALU results and condition codes, and produces branch targets.

Parameters:
- none

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_f  in  1  reset; asynchronous, active-low
- instruction  in  32  IR contents: op=[31:28], mm=[27:24], rd=[23:20], rs=[19:16], rt=[15:12], imm=[15:0]
- stat  in  4  status register contents {C,V,N,Z}
- rsa  in  32  register-file read port A (rs)
- rsb  in  32  register-file read port B (rt, or rd when rb_sel=1)
- pc_out  in  16  current PC
- alu_result  out  32  ALU result; the held swap value during WB2
- cc  out  4  condition codes {C,V,N,Z} of the current ALU operation
- stat_en  out  1  status-register load enable
- br_out  out  16  branch target
- rf_we  out  1  register-file write enable
- wb_sel  out  2  write-back source: 00 ALU, 01 dmem, 10 rsa, 11 rsb
- rb_sel  out  1  read port B select: 0 = rt, 1 = rd
- swap_sel  out  1  write-register select: 0 = rd, 1 = rs
- swap_ctrl  out  1  high during the second swap write
- pc_sel  out  1  PC input: 0 = pc+1, 1 = br_out
- pc_write  out  1  PC load enable
- pc_rst  out  1  PC clear, active-high
- ir_load  out  1  IR load enable
- mux_16_sel  out  1  dmem address: 0 = imm, 1 = alu_result[15:0]
- dm_we  out  1  data-memory write enable

Behaviour:
- Opcodes:
  - 0 NOP; 1 ALU-reg; 2 ALU-imm; 3 SWAP.
  - 4 BRA (absolute, branch if (stat&mm)!=0); 5 BRR (relative, same condition).
  - 6 BNE (absolute, branch if (stat&mm)==0); 7 BNR (relative, same condition).
  - 8 LOD; 9 STR; 15 HLT.
  - 10–14 behave as NOP.
- FSM states: START0, START1, FETCH, DECODE, EXECUTE, MEM, WB, WB2, HALT.
- Reset (rst_f low, asynchronous): state=START0; pc_rst=1; every other output 0.
- Transitions:
  - START0 -> START1 (pc_rst=1 in START0) -> FETCH.
  - FETCH -> DECODE -> EXECUTE -> MEM -> WB -> FETCH.
  - SWAP: WB -> WB2 -> FETCH.
  - HLT: DECODE -> HALT, which holds until reset.
- Control outputs are Moore (state plus IR); default 0.
- FETCH: ir_load=1, pc_write=1, pc_sel=0.
- DECODE, ops 4–7 with condition true: pc_sel=1, pc_write=1.
  - br_out = imm for BRA/BNE.
  - br_out = pc_out+imm (16-bit wrap) for BRR/BNR; pc_out is already incremented.
  - br_out is combinational at all times.
- EXECUTE, ops 1–2: stat_en=1 for one cycle.
- EXECUTE, SWAP: capture rsb (old rd, rb_sel=1) into swap_hold.
- MEM:
  - LOD/STR: mux_16_sel=mm[0]; address is imm, or rs+imm when mm[0]=1.
  - STR: dm_we=1, rb_sel=1 (data = rd).
- WB:
  - ops 1–2: rf_we=1, wb_sel=00, write rd.
  - LOD: rf_we=1, wb_sel=01.
  - SWAP: rf_we=1, wb_sel=10, swap_sel=0 (rd <= rs).
- WB2 (SWAP): rf_we=1, wb_sel=00, swap_sel=1, swap_ctrl=1, alu_result=swap_hold (rs <= old rd).
- rb_sel=1 throughout SWAP and STR; otherwise 0.
- ALU (combinational), operand B:
  - ALU-reg: rsb.
  - ALU-imm: sign-extended imm.
  - LOD/STR: zero-extended imm with function ADD.
- ALU functions by mm: 1 ADD, 2 SUB (A-B), 3 AND, 4 OR, 5 XOR, 6 NOT A, 7 SHL A by 1, 8 SHR A logical by 1; other codes pass A.
- Condition codes:
  - Z = result==0; N = result[31].
  - ADD: C = carry out, V = signed overflow.
  - SUB: C = borrow (A<B unsigned), V = signed overflow.
  - Shifts: C = bit shifted out, V = 0.
  - Logic/pass: C = V = 0.
- Reset mid-instruction aborts the instruction with no write.
- Status is updated only via stat_en; branches read stat as captured by earlier instructions.

Test Plan:
- Reset, then release -> pc_rst=1 in START0/START1; FETCH shows ir_load=1, pc_write=1; all write enables 0.
- ALU-reg ADD with rsa=0x7FFFFFFF, rsb=1 -> alu_result=0x80000000, cc=0110 with stat_en=1 in EXECUTE; rf_we=1, wb_sel=00 in WB.
- SUB with rsa=rsb=5 -> result 0, cc=0001; SUB 1-2 -> 0xFFFFFFFF, C=1, N=1.
- BRR, mm=0001, stat=0001, pc_out=0x0011, imm=0xFFFE -> br_out=0x000F, pc_sel=1, pc_write=1 in DECODE; with stat=0000 no PC load.
- SWAP, rsa=0xA, rsb=0xB -> WB writes 0xA to rd (wb_sel=10); WB2 writes alu_result=0xB to rs with swap_sel=1, swap_ctrl=1.
- STR, mm=1, rsa=0x10, imm=4 -> MEM shows alu_result[15:0]=0x14, mux_16_sel=1, dm_we=1, rb_sel=1. HLT -> stays in HALT with no enables until rst_f low.
